uart_param_core: RTL and testbench
==================================

// Module: uart_param_core
// PURPOSE
//  Parametrised full-duplex UART core: shared runtime-programmable baud tick, TX and RX FSMs,
//  DBIT data bits LSB-first, optional even/odd parity, 1 or 2 stop bits.
//  RX samples at mid-bit and reports parity and framing errors.
//  Sits between the processor I/O register block and the board TX/RX pins.
// PARAMETERS
//  DBIT   8   data bits per frame, legal 5..9
//  OVS    16  baud ticks per bit, even, >=4
//  DIV_W  16  width of BAUD_DIV
// PORTS
//  MAIN_CLOCK     in   1        system clock, all logic on rising edge
//  RESET          in   1        asynchronous, active-high
//  BAUD_DIV       in   DIV_W    clocks per baud tick; 0 treated as 1
//  PARITY_MODE    in   2        00 none, 01 even, 10 odd, 11 none
//  TWO_STOP       in   1        TX sends 2 stop bits when 1
//  TX_START       in   1        request to send TX_DATA
//  TX_DATA        in   DBIT     frame payload
//  TX_BUSY        out  1        TX FSM not idle
//  TX_DONE        out  1        1-cycle pulse, frame fully sent
//  TX_PIN         out  1        serial out, registered, idle high
//  RX_PIN         in   1        serial in, asynchronous to MAIN_CLOCK
//  RX_DATA        out  DBIT     last received payload, right-aligned
//  RX_VALID       out  1        1-cycle pulse, RX_DATA and error flags updated
//  RX_PARITY_ERR  out  1        parity mismatch on last frame
//  RX_FRAME_ERR   out  1        stop bit sampled 0 on last frame
//  TICK           out  1        baud tick, for debug
// BEHAVIOUR
//  Reset: TX_PIN=1; RX sync flops=1; TX_BUSY, TX_DONE, RX_VALID, errors, TICK=0; RX_DATA=0.
//   Both FSMs go to IDLE and counters clear. Reset mid-frame aborts immediately with no DONE/VALID.
//  Baud: counter 0..max(BAUD_DIV,1)-1. TICK=1 in the cycle the counter is at its top, then wraps to 0.
//   If BAUD_DIV drops below the current count, wrap on the next cycle.
//  Parity bit: even = ^data, odd = ~^data. Mode and TWO_STOP are latched at frame start,
//   so mid-frame changes are ignored.
//  TX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   - IDLE: TX_PIN=1. TX_START=1 accepts the frame: latch data and config, tick count=0, go START.
//   - TX_START while TX_BUSY is ignored, not queued.
//   - Each bit holds for OVS ticks. The first start bit may be short by <1 tick (shared free-running tick).
//   - DATA shifts LSB-first, DBIT bits. PARITY state only when mode is 01 or 10.
//   - STOP lasts OVS ticks, or 2*OVS if TWO_STOP. On its last tick: TX_DONE=1 for 1 cycle, go IDLE.
//   - TX_BUSY = (state!=IDLE), registered. TX_START in the same cycle as TX_DONE is ignored;
//     it is accepted from the next cycle.
//  RX path: 2-flop synchroniser on RX_PIN; all RX logic uses the synchronised signal.
//  RX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   - IDLE: start on synced falling edge (prev 1, now 0). Edge detection means a held-low line
//     (break) does not retrigger.
//   - START: at tick count OVS/2-1, line still 0 -> DATA, count=0. Line 1 -> false start, back to IDLE.
//   - DATA, PARITY, STOP: sample at tick count OVS-1, i.e. the bit centre.
//     DATA shifts in from the MSB side, DBIT bits.
//   - RX checks only the first stop bit; TWO_STOP does not affect RX.
//   - At the stop sample: RX_DATA<=shift reg, RX_PARITY_ERR<=mismatch (0 if parity none),
//     RX_FRAME_ERR<=~line, RX_VALID=1 for 1 cycle, back to IDLE the same cycle
//     (allows back-to-back frames).
//   - Data and flags hold until the next RX_VALID. The frame is delivered even when errors are set.
//  TX and RX are fully independent and may run simultaneously. Loopback TX_PIN->RX_PIN is legal.
// TESTING (OVS=16, DBIT=8, BAUD_DIV=4 -> 64 clocks/bit unless stated)
//  1 Loopback, parity none, TX_DATA=8'h4F: TX_PIN = 0,1,1,1,1,0,0,1,0,1, each 64+/-4 clocks.
//    Exactly one RX_VALID, RX_DATA=8'h4F, both errors 0. TX_DONE ~640 clocks after start.
//  2 Parity even, TX_DATA=8'h4B: parity bit 0. Odd mode: parity bit 1.
//    RX fed 8'h4B with inverted parity bit -> RX_VALID, RX_DATA=8'h4B, RX_PARITY_ERR=1.
//  3 RX stop bit driven 0, then line held low 10 bit times -> RX_VALID, RX_FRAME_ERR=1.
//    No further RX_VALID until the line rises and falls again.
//  4 RX_PIN low for 12 clocks (<half bit), then high -> no RX_VALID, RX back in IDLE,
//    next valid frame 8'hA5 received correctly.
//  5 TWO_STOP=1, parity odd, TX_DATA=8'h00: 12-bit frame, stop high 128 clocks.
//    TX_START pulsed mid-frame is ignored, giving one TX_DONE only.
//  6 RESET asserted mid-TX data bit and mid-RX -> TX_PIN=1 and TX_BUSY=0 immediately.
//    No TX_DONE or RX_VALID. A new frame after reset is exchanged correctly.

Source files
------------

// File: rtl/uart_param_core.sv
// Full-duplex UART core: shared programmable baud tick, independent TX and RX FSMs,
// DBIT data bits LSB-first, optional even/odd parity, 1 or 2 TX stop bits.
module uart_param_core #(
    parameter int unsigned DBIT  = 8,
    parameter int unsigned OVS   = 16,
    parameter int unsigned DIV_W = 16
) (
    input  logic             MAIN_CLOCK,
    input  logic             RESET,
    input  logic [DIV_W-1:0] BAUD_DIV,
    input  logic [1:0]       PARITY_MODE,
    input  logic             TWO_STOP,
    input  logic             TX_START,
    input  logic [DBIT-1:0]  TX_DATA,
    output logic             TX_BUSY,
    output logic             TX_DONE,
    output logic             TX_PIN,
    input  logic             RX_PIN,
    output logic [DBIT-1:0]  RX_DATA,
    output logic             RX_VALID,
    output logic             RX_PARITY_ERR,
    output logic             RX_FRAME_ERR,
    output logic             TICK
);

    localparam int unsigned TCNT_W = $clog2(2 * OVS);
    localparam int unsigned BCNT_W = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [TCNT_W-1:0] BIT_LAST   = TCNT_W'(OVS - 1);
    localparam logic [TCNT_W-1:0] HALF_LAST  = TCNT_W'(OVS / 2 - 1);
    localparam logic [TCNT_W-1:0] STOP2_LAST = TCNT_W'(2 * OVS - 1);
    localparam logic [BCNT_W-1:0] DBIT_LAST  = BCNT_W'(DBIT - 1);

    typedef enum logic [2:0] {
        TXS_IDLE,
        TXS_START,
        TXS_DATA,
        TXS_PAR,
        TXS_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RXS_IDLE,
        RXS_START,
        RXS_DATA,
        RXS_PAR,
        RXS_STOP
    } rx_state_t;

    // ---------------- baud tick ----------------
    logic [DIV_W-1:0] div_cnt, div_top, div_nxt;

    // A zero divider behaves as 1; a count above a lowered top wraps on the next cycle.
    always_comb begin
        div_top = (BAUD_DIV == '0) ? '0 : BAUD_DIV - DIV_W'(1);
        div_nxt = (div_cnt >= div_top) ? '0 : div_cnt + DIV_W'(1);
    end

    always_ff @(posedge MAIN_CLOCK or posedge RESET) begin
        if (RESET) begin
            div_cnt <= '0;
            TICK    <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            TICK    <= (div_nxt >= div_top);
        end
    end

    // ---------------- transmitter ----------------
    tx_state_t           tx_state, tx_state_n;
    logic [DBIT-1:0]     tx_shreg, tx_shreg_n;
    logic [TCNT_W-1:0]   tx_tcnt, tx_tcnt_n;
    logic [BCNT_W-1:0]   tx_bcnt, tx_bcnt_n;
    logic                tx_par, tx_par_n;
    logic                tx_par_en, tx_par_en_n;
    logic                tx_two_stop, tx_two_stop_n;
    logic                tx_pin_n, tx_busy_n, tx_done_n;

    always_ff @(posedge MAIN_CLOCK or posedge RESET) begin
        if (RESET) begin
            tx_state    <= TXS_IDLE;
            tx_shreg    <= '0;
            tx_tcnt     <= '0;
            tx_bcnt     <= '0;
            tx_par      <= 1'b0;
            tx_par_en   <= 1'b0;
            tx_two_stop <= 1'b0;
            TX_PIN      <= 1'b1;
            TX_BUSY     <= 1'b0;
            TX_DONE     <= 1'b0;
        end else begin
            tx_state    <= tx_state_n;
            tx_shreg    <= tx_shreg_n;
            tx_tcnt     <= tx_tcnt_n;
            tx_bcnt     <= tx_bcnt_n;
            tx_par      <= tx_par_n;
            tx_par_en   <= tx_par_en_n;
            tx_two_stop <= tx_two_stop_n;
            TX_PIN      <= tx_pin_n;
            TX_BUSY     <= tx_busy_n;
            TX_DONE     <= tx_done_n;
        end
    end

    always_comb begin
        tx_state_n    = tx_state;
        tx_shreg_n    = tx_shreg;
        tx_tcnt_n     = tx_tcnt;
        tx_bcnt_n     = tx_bcnt;
        tx_par_n      = tx_par;
        tx_par_en_n   = tx_par_en;
        tx_two_stop_n = tx_two_stop;
        tx_done_n     = 1'b0;

        unique case (tx_state)
            TXS_IDLE: begin
                // A request coinciding with the DONE pulse is dropped, not deferred.
                if (TX_START && !TX_DONE) begin
                    tx_state_n    = TXS_START;
                    tx_shreg_n    = TX_DATA;
                    tx_tcnt_n     = '0;
                    tx_bcnt_n     = '0;
                    tx_par_n      = (^TX_DATA) ^ PARITY_MODE[1];
                    tx_par_en_n   = ^PARITY_MODE;
                    tx_two_stop_n = TWO_STOP;
                end
            end
            TXS_START: begin
                if (TICK) begin
                    if (tx_tcnt == BIT_LAST) begin
                        tx_tcnt_n  = '0;
                        tx_state_n = TXS_DATA;
                    end else begin
                        tx_tcnt_n = tx_tcnt + TCNT_W'(1);
                    end
                end
            end
            TXS_DATA: begin
                if (TICK) begin
                    if (tx_tcnt == BIT_LAST) begin
                        tx_tcnt_n = '0;
                        if (tx_bcnt == DBIT_LAST) begin
                            tx_state_n = tx_par_en ? TXS_PAR : TXS_STOP;
                        end else begin
                            tx_bcnt_n  = tx_bcnt + BCNT_W'(1);
                            tx_shreg_n = tx_shreg >> 1;
                        end
                    end else begin
                        tx_tcnt_n = tx_tcnt + TCNT_W'(1);
                    end
                end
            end
            TXS_PAR: begin
                if (TICK) begin
                    if (tx_tcnt == BIT_LAST) begin
                        tx_tcnt_n  = '0;
                        tx_state_n = TXS_STOP;
                    end else begin
                        tx_tcnt_n = tx_tcnt + TCNT_W'(1);
                    end
                end
            end
            TXS_STOP: begin
                if (TICK) begin
                    if (tx_tcnt == (tx_two_stop ? STOP2_LAST : BIT_LAST)) begin
                        tx_tcnt_n  = '0;
                        tx_state_n = TXS_IDLE;
                        tx_done_n  = 1'b1;
                    end else begin
                        tx_tcnt_n = tx_tcnt + TCNT_W'(1);
                    end
                end
            end
            default: tx_state_n = TXS_IDLE;
        endcase

        // Line level is decoded from the next state so TX_PIN stays a plain flop.
        unique case (tx_state_n)
            TXS_START: tx_pin_n = 1'b0;
            TXS_DATA:  tx_pin_n = tx_shreg_n[0];
            TXS_PAR:   tx_pin_n = tx_par_n;
            default:   tx_pin_n = 1'b1;
        endcase
        tx_busy_n = (tx_state_n != TXS_IDLE);
    end

    // ---------------- receiver ----------------
    rx_state_t           rx_state, rx_state_n;
    logic                rx_s1, rx_s2, rx_prev;
    logic [TCNT_W-1:0]   rx_tcnt, rx_tcnt_n;
    logic [BCNT_W-1:0]   rx_bcnt, rx_bcnt_n;
    logic [DBIT-1:0]     rx_shreg, rx_shreg_n;
    logic                rx_par_en, rx_par_en_n;
    logic                rx_par_odd, rx_par_odd_n;
    logic                rx_perr, rx_perr_n;
    logic [DBIT-1:0]     rx_data_n;
    logic                rx_valid_n, rx_perr_out_n, rx_ferr_n;
    logic                rx_fall;

    assign rx_fall = rx_prev & ~rx_s2;

    always_ff @(posedge MAIN_CLOCK or posedge RESET) begin
        if (RESET) begin
            rx_s1         <= 1'b1;
            rx_s2         <= 1'b1;
            rx_prev       <= 1'b1;
            rx_state      <= RXS_IDLE;
            rx_tcnt       <= '0;
            rx_bcnt       <= '0;
            rx_shreg      <= '0;
            rx_par_en     <= 1'b0;
            rx_par_odd    <= 1'b0;
            rx_perr       <= 1'b0;
            RX_DATA       <= '0;
            RX_VALID      <= 1'b0;
            RX_PARITY_ERR <= 1'b0;
            RX_FRAME_ERR  <= 1'b0;
        end else begin
            rx_s1         <= RX_PIN;
            rx_s2         <= rx_s1;
            rx_prev       <= rx_s2;
            rx_state      <= rx_state_n;
            rx_tcnt       <= rx_tcnt_n;
            rx_bcnt       <= rx_bcnt_n;
            rx_shreg      <= rx_shreg_n;
            rx_par_en     <= rx_par_en_n;
            rx_par_odd    <= rx_par_odd_n;
            rx_perr       <= rx_perr_n;
            RX_DATA       <= rx_data_n;
            RX_VALID      <= rx_valid_n;
            RX_PARITY_ERR <= rx_perr_out_n;
            RX_FRAME_ERR  <= rx_ferr_n;
        end
    end

    always_comb begin
        rx_state_n    = rx_state;
        rx_tcnt_n     = rx_tcnt;
        rx_bcnt_n     = rx_bcnt;
        rx_shreg_n    = rx_shreg;
        rx_par_en_n   = rx_par_en;
        rx_par_odd_n  = rx_par_odd;
        rx_perr_n     = rx_perr;
        rx_data_n     = RX_DATA;
        rx_perr_out_n = RX_PARITY_ERR;
        rx_ferr_n     = RX_FRAME_ERR;
        rx_valid_n    = 1'b0;

        unique case (rx_state)
            RXS_IDLE: begin
                // Edge-triggered start so a held-low break line cannot retrigger.
                if (rx_fall) begin
                    rx_state_n   = RXS_START;
                    rx_tcnt_n    = '0;
                    rx_bcnt_n    = '0;
                    rx_par_en_n  = ^PARITY_MODE;
                    rx_par_odd_n = PARITY_MODE[1];
                    rx_perr_n    = 1'b0;
                end
            end
            RXS_START: begin
                if (TICK) begin
                    if (rx_tcnt == HALF_LAST) begin
                        rx_tcnt_n  = '0;
                        rx_state_n = rx_s2 ? RXS_IDLE : RXS_DATA;
                    end else begin
                        rx_tcnt_n = rx_tcnt + TCNT_W'(1);
                    end
                end
            end
            RXS_DATA: begin
                if (TICK) begin
                    if (rx_tcnt == BIT_LAST) begin
                        rx_tcnt_n  = '0;
                        rx_shreg_n = {rx_s2, rx_shreg[DBIT-1:1]};
                        if (rx_bcnt == DBIT_LAST) begin
                            rx_state_n = rx_par_en ? RXS_PAR : RXS_STOP;
                        end else begin
                            rx_bcnt_n = rx_bcnt + BCNT_W'(1);
                        end
                    end else begin
                        rx_tcnt_n = rx_tcnt + TCNT_W'(1);
                    end
                end
            end
            RXS_PAR: begin
                if (TICK) begin
                    if (rx_tcnt == BIT_LAST) begin
                        rx_tcnt_n  = '0;
                        rx_perr_n  = rx_s2 ^ (^rx_shreg) ^ rx_par_odd;
                        rx_state_n = RXS_STOP;
                    end else begin
                        rx_tcnt_n = rx_tcnt + TCNT_W'(1);
                    end
                end
            end
            RXS_STOP: begin
                // Frame is delivered even with errors; IDLE is re-entered at once for back-to-back frames.
                if (TICK) begin
                    if (rx_tcnt == BIT_LAST) begin
                        rx_tcnt_n     = '0;
                        rx_data_n     = rx_shreg;
                        rx_perr_out_n = rx_perr;
                        rx_ferr_n     = ~rx_s2;
                        rx_valid_n    = 1'b1;
                        rx_state_n    = RXS_IDLE;
                    end else begin
                        rx_tcnt_n = rx_tcnt + TCNT_W'(1);
                    end
                end
            end
            default: rx_state_n = RXS_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_param_core.sv
// Directed bench for uart_param_core: OVS=16, DBIT=8, BAUD_DIV=4 (64 clocks per bit).
module tb_uart_param_core;

    localparam int unsigned DBIT  = 8;
    localparam int unsigned OVS   = 16;
    localparam int unsigned DIV_W = 16;

    logic             MAIN_CLOCK = 1'b0;
    logic             RESET;
    logic [DIV_W-1:0] BAUD_DIV;
    logic [1:0]       PARITY_MODE;
    logic             TWO_STOP;
    logic             TX_START;
    logic [DBIT-1:0]  TX_DATA;
    logic             TX_BUSY, TX_DONE, TX_PIN;
    logic             RX_PIN;
    logic [DBIT-1:0]  RX_DATA;
    logic             RX_VALID, RX_PARITY_ERR, RX_FRAME_ERR, TICK;

    logic loop, rx_drv;
    assign RX_PIN = loop ? TX_PIN : rx_drv;

    int tests = 0;
    int fails = 0;
    int rx_valid_cnt = 0;
    int tx_done_cnt = 0;

    uart_param_core #(.DBIT(DBIT), .OVS(OVS), .DIV_W(DIV_W)) dut (
        .MAIN_CLOCK   (MAIN_CLOCK),
        .RESET        (RESET),
        .BAUD_DIV     (BAUD_DIV),
        .PARITY_MODE  (PARITY_MODE),
        .TWO_STOP     (TWO_STOP),
        .TX_START     (TX_START),
        .TX_DATA      (TX_DATA),
        .TX_BUSY      (TX_BUSY),
        .TX_DONE      (TX_DONE),
        .TX_PIN       (TX_PIN),
        .RX_PIN       (RX_PIN),
        .RX_DATA      (RX_DATA),
        .RX_VALID     (RX_VALID),
        .RX_PARITY_ERR(RX_PARITY_ERR),
        .RX_FRAME_ERR (RX_FRAME_ERR),
        .TICK         (TICK)
    );

    always #5 MAIN_CLOCK = ~MAIN_CLOCK;

    always @(negedge MAIN_CLOCK) begin
        if (RX_VALID === 1'b1) rx_valid_cnt++;
        if (TX_DONE === 1'b1) tx_done_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start a TX frame and check TX_PIN at every bit centre, plus TX_DONE timing.
    task automatic run_tx(input string tag, input logic [7:0] data, input int nbits,
                          input logic [15:0] exp_bits, input int pulse_bit);
        int n;
        @(negedge MAIN_CLOCK);
        TX_DATA  = data;
        TX_START = 1'b1;
        @(negedge MAIN_CLOCK);
        TX_START = 1'b0;
        n = 0;
        for (int m = 0; m < nbits; m++) begin
            while (n < 32 + 64 * m) begin
                @(negedge MAIN_CLOCK);
                n++;
            end
            check($sformatf("%s_bit%0d", tag, m), 32'(TX_PIN), 32'(exp_bits[m]));
            if (m == pulse_bit) begin
                TX_DATA  = 8'hFF;
                TX_START = 1'b1;
                @(negedge MAIN_CLOCK);
                n++;
                TX_START = 1'b0;
            end
        end
        while (TX_DONE !== 1'b1 && n < 3000) begin
            @(negedge MAIN_CLOCK);
            n++;
        end
        check($sformatf("%s_done_time(n=%0d)", tag, n),
              32'(n >= 64 * nbits - 4 && n <= 64 * nbits + 1), 32'd1);
        @(negedge MAIN_CLOCK);
    endtask

    task automatic rx_frame(input logic [7:0] d, input bit use_par, input logic par, input logic stop);
        rx_drv = 1'b0;
        repeat (64) @(negedge MAIN_CLOCK);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            repeat (64) @(negedge MAIN_CLOCK);
        end
        if (use_par) begin
            rx_drv = par;
            repeat (64) @(negedge MAIN_CLOCK);
        end
        rx_drv = stop;
        repeat (64) @(negedge MAIN_CLOCK);
    endtask

    initial begin
        int rb, td, ticks;
        RESET       = 1'b1;
        BAUD_DIV    = 16'd4;
        PARITY_MODE = 2'b00;
        TWO_STOP    = 1'b0;
        TX_START    = 1'b0;
        TX_DATA     = '0;
        loop        = 1'b1;
        rx_drv      = 1'b1;
        repeat (3) @(negedge MAIN_CLOCK);

        check("rst_tx_pin", 32'(TX_PIN), 32'd1);
        check("rst_tx_busy", 32'(TX_BUSY), 32'd0);
        check("rst_tx_done", 32'(TX_DONE), 32'd0);
        check("rst_rx_valid", 32'(RX_VALID), 32'd0);
        check("rst_rx_data", 32'(RX_DATA), 32'd0);
        check("rst_errs", 32'({RX_PARITY_ERR, RX_FRAME_ERR}), 32'd0);
        check("rst_tick", 32'(TICK), 32'd0);
        RESET = 1'b0;

        // Baud tick: one per 4 clocks, and every clock when the divider is 0
        ticks = 0;
        repeat (40) begin
            @(negedge MAIN_CLOCK);
            if (TICK) ticks++;
        end
        check("tick_div4", 32'(ticks), 32'd10);
        BAUD_DIV = 16'd0;
        repeat (2) @(negedge MAIN_CLOCK);
        ticks = 0;
        repeat (10) begin
            @(negedge MAIN_CLOCK);
            if (TICK) ticks++;
        end
        check("tick_div0", 32'(ticks), 32'd10);
        BAUD_DIV = 16'd4;
        repeat (8) @(negedge MAIN_CLOCK);

        // 1: loopback, no parity, 0x4F
        rb = rx_valid_cnt; td = tx_done_cnt;
        run_tx("t1", 8'h4F, 10, 16'h029E, -1);
        repeat (100) @(negedge MAIN_CLOCK);
        check("t1_rx_count", 32'(rx_valid_cnt - rb), 32'd1);
        check("t1_tx_done_count", 32'(tx_done_cnt - td), 32'd1);
        check("t1_rx_data", 32'(RX_DATA), 32'h4F);
        check("t1_errs", 32'({RX_PARITY_ERR, RX_FRAME_ERR}), 32'd0);

        // 2: even then odd parity on 0x4B, then RX with a wrong parity bit
        PARITY_MODE = 2'b01;
        rb = rx_valid_cnt;
        run_tx("t2e", 8'h4B, 11, 16'h0496, -1);
        repeat (100) @(negedge MAIN_CLOCK);
        check("t2e_rx_count", 32'(rx_valid_cnt - rb), 32'd1);
        check("t2e_rx_data", 32'(RX_DATA), 32'h4B);
        check("t2e_perr", 32'(RX_PARITY_ERR), 32'd0);
        PARITY_MODE = 2'b10;
        run_tx("t2o", 8'h4B, 11, 16'h0696, -1);
        repeat (100) @(negedge MAIN_CLOCK);
        check("t2o_rx_data", 32'(RX_DATA), 32'h4B);
        check("t2o_perr", 32'(RX_PARITY_ERR), 32'd0);
        loop = 1'b0;
        PARITY_MODE = 2'b01;
        rb = rx_valid_cnt;
        rx_frame(8'h4B, 1'b1, 1'b1, 1'b1);
        repeat (64) @(negedge MAIN_CLOCK);
        check("t2p_rx_count", 32'(rx_valid_cnt - rb), 32'd1);
        check("t2p_rx_data", 32'(RX_DATA), 32'h4B);
        check("t2p_perr", 32'(RX_PARITY_ERR), 32'd1);
        check("t2p_ferr", 32'(RX_FRAME_ERR), 32'd0);

        // 3: stop bit 0 followed by a long break
        PARITY_MODE = 2'b00;
        rb = rx_valid_cnt;
        rx_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        check("t3_rx_count", 32'(rx_valid_cnt - rb), 32'd1);
        check("t3_rx_data", 32'(RX_DATA), 32'h3C);
        check("t3_ferr", 32'(RX_FRAME_ERR), 32'd1);
        check("t3_perr", 32'(RX_PARITY_ERR), 32'd0);
        repeat (640) @(negedge MAIN_CLOCK);
        check("t3_break_no_retrigger", 32'(rx_valid_cnt - rb), 32'd1);
        rx_drv = 1'b1;
        repeat (128) @(negedge MAIN_CLOCK);
        check("t3_rise_no_valid", 32'(rx_valid_cnt - rb), 32'd1);
        rx_frame(8'h5A, 1'b0, 1'b0, 1'b1);
        repeat (64) @(negedge MAIN_CLOCK);
        check("t3_next_count", 32'(rx_valid_cnt - rb), 32'd2);
        check("t3_next_data", 32'(RX_DATA), 32'h5A);
        check("t3_next_ferr", 32'(RX_FRAME_ERR), 32'd0);

        // 4: 12-clock glitch is a false start
        rb = rx_valid_cnt;
        rx_drv = 1'b0;
        repeat (12) @(negedge MAIN_CLOCK);
        rx_drv = 1'b1;
        repeat (200) @(negedge MAIN_CLOCK);
        check("t4_glitch_no_valid", 32'(rx_valid_cnt - rb), 32'd0);
        rx_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        repeat (64) @(negedge MAIN_CLOCK);
        check("t4_rx_count", 32'(rx_valid_cnt - rb), 32'd1);
        check("t4_rx_data", 32'(RX_DATA), 32'hA5);
        check("t4_errs", 32'({RX_PARITY_ERR, RX_FRAME_ERR}), 32'd0);

        // 5: two stop bits, odd parity, 0x00, TX_START pulsed mid-frame
        loop = 1'b1;
        PARITY_MODE = 2'b10;
        TWO_STOP = 1'b1;
        rb = rx_valid_cnt; td = tx_done_cnt;
        run_tx("t5", 8'h00, 12, 16'h0E00, 4);
        TWO_STOP = 1'b0;
        repeat (900) @(negedge MAIN_CLOCK);
        check("t5_done_count", 32'(tx_done_cnt - td), 32'd1);
        check("t5_busy_after", 32'(TX_BUSY), 32'd0);
        check("t5_rx_count", 32'(rx_valid_cnt - rb), 32'd1);
        check("t5_rx_data", 32'(RX_DATA), 32'h00);
        check("t5_perr", 32'(RX_PARITY_ERR), 32'd0);

        // 6: reset mid-frame, then a clean exchange
        PARITY_MODE = 2'b00;
        rb = rx_valid_cnt; td = tx_done_cnt;
        @(negedge MAIN_CLOCK);
        TX_DATA  = 8'hC3;
        TX_START = 1'b1;
        @(negedge MAIN_CLOCK);
        TX_START = 1'b0;
        repeat (32 + 64 * 3) @(negedge MAIN_CLOCK);
        check("t6_busy_before", 32'(TX_BUSY), 32'd1);
        RESET = 1'b1;
        #1;
        check("t6_rst_tx_pin", 32'(TX_PIN), 32'd1);
        check("t6_rst_tx_busy", 32'(TX_BUSY), 32'd0);
        repeat (4) @(negedge MAIN_CLOCK);
        RESET = 1'b0;
        repeat (1000) @(negedge MAIN_CLOCK);
        check("t6_no_done", 32'(tx_done_cnt - td), 32'd0);
        check("t6_no_valid", 32'(rx_valid_cnt - rb), 32'd0);
        run_tx("t6", 8'h96, 10, 16'h032C, -1);
        repeat (100) @(negedge MAIN_CLOCK);
        check("t6_done_count", 32'(tx_done_cnt - td), 32'd1);
        check("t6_rx_count", 32'(rx_valid_cnt - rb), 32'd1);
        check("t6_rx_data", 32'(RX_DATA), 32'h96);
        check("t6_errs", 32'({RX_PARITY_ERR, RX_FRAME_ERR}), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
